// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - receive-side byte handshake between spi_slave_rx and its consumer
//
// Purpose: bundles the byte holding register outputs, status pulses and the
//          consumer acknowledge.
// Signals:
//   RX_ACK     consumer -> rx   acknowledge, clears RX_VALID
//   RX_DATA    rx -> consumer   last completed byte
//   RX_VALID   rx -> consumer   unacknowledged byte present
//   RX_OVR     rx -> consumer   one-cycle overrun pulse
//   FRAME_ERR  rx -> consumer   one-cycle partial-byte pulse
//   BUSY       rx -> consumer   receiver inside a frame
// Modports: slave = receiver side, master = consumer side.

interface spi_slave_rx_if #(
    parameter int DATA_W = 8
);
    logic              RX_ACK;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_VALID;
    logic              RX_OVR;
    logic              FRAME_ERR;
    logic              BUSY;

    modport slave (
        input  RX_ACK,
        output RX_DATA,
        output RX_VALID,
        output RX_OVR,
        output FRAME_ERR,
        output BUSY
    );

    modport master (
        output RX_ACK,
        input  RX_DATA,
        input  RX_VALID,
        input  RX_OVR,
        input  FRAME_ERR,
        input  BUSY
    );
endinterface

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - oversampling SPI responder, receive path only
//
// Purpose: synchronises SCLK/CS/SDI into CLK, reassembles MSB-first bytes on
//          SCLK rising edges inside a CS-low frame and presents them through a
//          valid/ack holding register with overrun and framing-error pulses.
// Ports:
//   CLK   system clock, rising edge
//   RST   synchronous active-high reset
//   SCLK  external SPI clock (idle high, asynchronous)
//   CS    external chip select (active low, asynchronous)
//   SDI   external serial data (asynchronous)
//   rx    byte handshake interface (slave modport)

module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          SCLK,
    input  logic          CS,
    input  logic          SDI,
    spi_slave_rx_if.slave rx
);

    localparam int          CNT_W      = $clog2(DATA_W);
    localparam logic [2:0]  SETTLE_MAX = 3'(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RECV = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. All reset to the link idle level so a reset
    // never manufactures an edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_hist;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            sdi_sync  <= '1;
            sclk_hist <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, sdi_s, rise_evt;
    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign rise_evt = sclk_s & ~sclk_hist;

    // The synchroniser output reads the forced idle level for SYNC_STAGES
    // cycles after reset. Arm must not treat that as a real CS high, or a
    // reset in the middle of a frame would rejoin that frame mid-byte.
    logic [2:0] settle_cnt;
    logic       settled;
    assign settled = (settle_cnt == SETTLE_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_cnt <= 3'd0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  shift_next;
    logic               do_shift, do_clear, frame_err_nxt, busy;
    logic               byte_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_ARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        do_shift      = 1'b0;
        do_clear      = 1'b0;
        frame_err_nxt = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_ARM: begin
                if (settled && cs_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!cs_s) begin
                    state_nxt = ST_RECV;
                    do_clear  = 1'b1;
                end
            end
            ST_RECV: begin
                busy = 1'b1;
                // CS release takes priority over a coincident SCLK edge.
                if (cs_s) begin
                    state_nxt     = ST_IDLE;
                    do_clear      = 1'b1;
                    frame_err_nxt = (bit_cnt != '0);
                end else if (rise_evt) begin
                    do_shift = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ARM;
            end
        endcase
    end

    assign shift_next = {shift_reg[DATA_W-2:0], sdi_s};
    assign byte_done  = do_shift && (bit_cnt == CNT_W'(DATA_W - 1));

    // ------------------------------------------------------------------
    // Datapath and holding register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q, rx_ovr_q, frame_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_ovr_q    <= 1'b0;
            frame_err_q <= frame_err_nxt;

            if (do_clear) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (do_shift) begin
                shift_reg <= shift_next;
                bit_cnt   <= byte_done ? '0 : bit_cnt + CNT_W'(1);
            end

            // A completion coinciding with an ack hands over the new byte
            // cleanly; only an unacknowledged old byte counts as overrun.
            if (byte_done) begin
                rx_data_q  <= shift_next;
                rx_valid_q <= 1'b1;
                rx_ovr_q   <= rx_valid_q & ~rx.RX_ACK;
            end else if (rx.RX_ACK && rx_valid_q) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx.RX_DATA   = rx_data_q;
    assign rx.RX_VALID  = rx_valid_q;
    assign rx.RX_OVR    = rx_ovr_q;
    assign rx.FRAME_ERR = frame_err_q;
    assign rx.BUSY      = busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - self-checking bench for spi_slave_rx

module tb_spi_slave_rx;

    localparam int S    = 2;
    localparam int W    = 8;
    localparam int HALF = 16;

    logic CLK  = 1'b0;
    logic RST  = 1'b1;
    logic SCLK = 1'b1;
    logic CS   = 1'b1;
    logic SDI  = 1'b1;

    spi_slave_rx_if #(.DATA_W(W)) rx_if ();

    spi_slave_rx #(.SYNC_STAGES(S), .DATA_W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .SCLK(SCLK),
        .CS  (CS),
        .SDI (SDI),
        .rx  (rx_if.slave)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the receiver sees the pins S cycles late. Pin
    // samples are queued; a reset replaces the pending view with the idle
    // level and marks it as not yet reflecting the real pins.
    // ------------------------------------------------------------------
    logic hs_sclk[$], hs_cs[$], hs_sdi[$];
    bit   hs_real[$];
    int   m_mode = 0;        // 0 armed-wait, 1 idle, 2 in frame
    bit   m_bits[$];
    logic [7:0] m_data = 8'h00;
    logic m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    logic [7:0] m_bytes[$];
    bit   started = 1'b0;

    task automatic model_step();
        logic pc, sc, csv, sd, ack;
        bit   rl, done;
        logic [7:0] nb;
        hs_sclk.push_back(SCLK);
        hs_cs.push_back(CS);
        hs_sdi.push_back(SDI);
        hs_real.push_back(1'b1);
        if (hs_sclk.size() > S + 2) begin
            void'(hs_sclk.pop_front());
            void'(hs_cs.pop_front());
            void'(hs_sdi.pop_front());
            void'(hs_real.pop_front());
        end
        ack    = rx_if.RX_ACK;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        if (RST) begin
            foreach (hs_sclk[i]) begin
                hs_sclk[i] = 1'b1;
                hs_cs[i]   = 1'b1;
                hs_sdi[i]  = 1'b1;
                hs_real[i] = 1'b0;
            end
            m_mode  = 0;
            m_bits.delete();
            m_data  = 8'h00;
            m_valid = 1'b0;
            return;
        end
        if (hs_sclk.size() < S + 2) return;
        pc   = hs_sclk[0];
        sc   = hs_sclk[1];
        csv  = hs_cs[1];
        sd   = hs_sdi[1];
        rl   = hs_real[1];
        done = 1'b0;
        nb   = 8'h00;
        case (m_mode)
            0: if (rl && csv) m_mode = 1;
            1: if (!csv) begin
                m_mode = 2;
                m_bits.delete();
            end
            default: begin
                if (csv) begin
                    m_mode = 1;
                    if (m_bits.size() != 0) m_ferr = 1'b1;
                    m_bits.delete();
                end else if (sc && !pc) begin
                    m_bits.push_back(sd);
                    if (m_bits.size() == W) begin
                        for (int i = 0; i < W; i++) nb[W-1-i] = m_bits[i];
                        m_bits.delete();
                        done = 1'b1;
                    end
                end
            end
        endcase
        if (done) begin
            m_ovr   = m_valid && !ack;
            m_data  = nb;
            m_valid = 1'b1;
            m_bytes.push_back(nb);
        end else if (ack && m_valid) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
            started = 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge CLK);
            if (started) begin
                chk("cycle", {19'd0, rx_if.RX_DATA, rx_if.RX_VALID, rx_if.RX_OVR,
                              rx_if.FRAME_ERR, rx_if.BUSY},
                    {19'd0, m_data, m_valid, m_ovr, m_ferr, (m_mode == 2)});
            end
        end
    end

    // Event counters on the DUT outputs for the per-test literal checks
    int   cnt_vrise = 0, cnt_ovr = 0, cnt_ferr = 0;
    logic prev_valid = 1'b0;
    logic [7:0] dut_bytes[$];

    initial begin
        forever begin
            @(negedge CLK);
            if (rx_if.RX_VALID === 1'b1 && prev_valid !== 1'b1) begin
                cnt_vrise++;
                dut_bytes.push_back(rx_if.RX_DATA);
            end
            if (rx_if.RX_OVR === 1'b1) cnt_ovr++;
            if (rx_if.FRAME_ERR === 1'b1) cnt_ferr++;
            prev_valid = rx_if.RX_VALID;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clr_counts();
        cnt_vrise = 0;
        cnt_ovr   = 0;
        cnt_ferr  = 0;
        dut_bytes.delete();
    endtask

    task automatic send_bit(input logic b);
        SCLK = 1'b0;
        SDI  = b;
        tick(HALF);
        SCLK = 1'b1;
        tick(HALF);
    endtask

    // ack_coll raises RX_ACK exactly in the cycle the byte completes:
    // the last rise reaches the receiver S cycles later and is registered
    // on the following edge.
    task automatic send_byte(input logic [7:0] v, input bit ack_coll);
        for (int i = 7; i >= 0; i--) begin
            SCLK = 1'b0;
            SDI  = v[i];
            tick(HALF);
            SCLK = 1'b1;
            if (i == 0 && ack_coll) begin
                tick(S);
                rx_if.RX_ACK = 1'b1;
                tick(1);
                rx_if.RX_ACK = 1'b0;
                tick(HALF - S - 1);
            end else begin
                tick(HALF);
            end
        end
    endtask

    task automatic cs_low();
        CS = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        CS = 1'b1;
        tick(HALF);
    endtask

    task automatic ack_pulse();
        rx_if.RX_ACK = 1'b1;
        tick(1);
        rx_if.RX_ACK = 1'b0;
        tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    logic [7:0] exp_all[10];

    initial begin
        rx_if.RX_ACK = 1'b0;
        tick(5);
        chk("reset_valid", {31'd0, rx_if.RX_VALID}, 32'd0);
        chk("reset_data", {24'd0, rx_if.RX_DATA}, 32'd0);
        chk("reset_busy", {31'd0, rx_if.BUSY}, 32'd0);
        RST = 1'b0;
        tick(10);

        // Single byte
        clr_counts();
        cs_low();
        send_byte(8'hA5, 1'b0);
        cs_high();
        chk("single_vrise", cnt_vrise, 1);
        chk("single_data", {24'd0, rx_if.RX_DATA}, 32'hA5);
        chk("single_ferr", cnt_ferr, 0);
        chk("single_ovr", cnt_ovr, 0);
        chk("single_busy", {31'd0, rx_if.BUSY}, 32'd0);
        ack_pulse();
        chk("single_ack", {31'd0, rx_if.RX_VALID}, 32'd0);

        // Burst with ack after each byte
        clr_counts();
        cs_low();
        send_byte(8'h3C, 1'b0); ack_pulse();
        send_byte(8'hFF, 1'b0); ack_pulse();
        send_byte(8'h00, 1'b0); ack_pulse();
        cs_high();
        chk("burst_vrise", cnt_vrise, 3);
        if (dut_bytes.size() == 3) begin
            chk("burst_b0", {24'd0, dut_bytes[0]}, 32'h3C);
            chk("burst_b1", {24'd0, dut_bytes[1]}, 32'hFF);
            chk("burst_b2", {24'd0, dut_bytes[2]}, 32'h00);
        end
        chk("burst_ovr", cnt_ovr, 0);
        chk("burst_ferr", cnt_ferr, 0);

        // Overrun
        clr_counts();
        cs_low();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        cs_high();
        chk("ovr_count", cnt_ovr, 1);
        chk("ovr_data", {24'd0, rx_if.RX_DATA}, 32'h34);
        chk("ovr_valid", {31'd0, rx_if.RX_VALID}, 32'd1);
        ack_pulse();
        chk("ovr_ack", {31'd0, rx_if.RX_VALID}, 32'd0);

        // Ack collides with completion of the second byte
        clr_counts();
        cs_low();
        send_byte(8'h9A, 1'b0);
        send_byte(8'h56, 1'b1);
        cs_high();
        chk("coll_valid", {31'd0, rx_if.RX_VALID}, 32'd1);
        chk("coll_data", {24'd0, rx_if.RX_DATA}, 32'h56);
        chk("coll_ovr", cnt_ovr, 0);
        ack_pulse();

        // Framing error: 5 bits then CS high, followed by a good frame
        clr_counts();
        cs_low();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        cs_high();
        chk("ferr_count", cnt_ferr, 1);
        chk("ferr_valid", {31'd0, rx_if.RX_VALID}, 32'd0);
        cs_low();
        send_byte(8'h81, 1'b0);
        cs_high();
        chk("ferr_next_data", {24'd0, rx_if.RX_DATA}, 32'h81);
        chk("ferr_next_count", cnt_ferr, 1);
        ack_pulse();

        // Reset in the middle of a frame
        clr_counts();
        cs_low();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        chk("rst_busy", {31'd0, rx_if.BUSY}, 32'd0);
        cs_high();
        chk("rst_vrise", cnt_vrise, 0);
        chk("rst_ferr", cnt_ferr, 0);
        cs_low();
        send_byte(8'hC3, 1'b0);
        cs_high();
        chk("rst_next_data", {24'd0, rx_if.RX_DATA}, 32'hC3);
        chk("rst_next_vrise", cnt_vrise, 1);
        chk("rst_next_ferr", cnt_ferr, 0);

        // Pin the model's own byte stream against hand-written values
        exp_all = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h9A, 8'h56, 8'h81, 8'hC3};
        chk("model_count", m_bytes.size(), 10);
        if (m_bytes.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("model_byte%0d", i), {24'd0, m_bytes[i]}, {24'd0, exp_all[i]});
            end
        end

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI responder (receive side) for the byte-oriented SPI link driven by the team's SPI master.
- Link convention: CS active-low; SCLK idles high; data changes on SCLK falling edge and is sampled on the rising edge; MSB first; 8-bit words.
- Oversamples the external SCLK, CS and SDI in the system CLK domain and reassembles bytes. Presents each byte through a valid/ack holding register.
- Reports overrun and framing errors. Supports multiple back-to-back bytes in one CS-low frame.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on SCLK, CS and SDI. Legal range 2..4.
- DATA_W, 8: bits per word. Fixed at 8 for the current link; other values need not be verified.

Ports:
- CLK  input  1  system clock; all logic is on its rising edge.
- RST  input  1  synchronous, active-high reset.
- SCLK  input  1  external SPI clock, asynchronous to CLK, idle high.
- CS  input  1  external chip select, active low, asynchronous.
- SDI  input  1  external serial data in, asynchronous.
- RX_ACK  input  1  consumer acknowledge; clears RX_VALID.
- RX_DATA  output  DATA_W  last completed byte; held until the next byte completes.
- RX_VALID  output  1  level; high while RX_DATA holds an unacknowledged byte.
- RX_OVR  output  1  one-CLK pulse: byte completed while RX_VALID was high and RX_ACK was low.
- FRAME_ERR  output  1  one-CLK pulse: CS rose with a partial byte (1..DATA_W-1 bits).
- BUSY  output  1  high while in state Recv.

Behaviour:
- Reset values: RX_DATA=0, RX_VALID=0, RX_OVR=0, FRAME_ERR=0, BUSY=0, bit counter=0, shift register=0, state=Arm.
- Synchronizer flops reset to the idle level: SCLK=1, CS=1, SDI=1.
- Synchronizers:
  - SCLK, CS and SDI each pass through SYNC_STAGES flops plus one history flop.
  - rise_evt = synced SCLK high AND history low.
  - cs_fall / cs_rise are defined the same way on CS.
  - SDI uses the same depth, so the sampled bit aligns with rise_evt.
- Input timing requirement: SCLK high and low phases are each at least SYNC_STAGES+2 CLK periods. The master's 16-CLK half period is compliant.
- State machine:
  - Arm: waits for synced CS = 1, then goes to Idle. Prevents joining a frame mid-stream after reset.
  - Idle: on synced CS = 0 go to Recv, clear the bit counter and clear the shift register.
  - Recv, on rise_evt:
    - shift_reg <= {shift_reg[DATA_W-2:0], sdi_synced}; bit_cnt++.
    - When bit_cnt reaches DATA_W: load RX_DATA from the completed shift value, set RX_VALID, reset bit_cnt to 0, stay in Recv.
  - Recv, on synced CS = 1: go to Idle. If bit_cnt != 0, pulse FRAME_ERR and discard the partial bits. If bit_cnt == 0, end the frame silently.
  - Any undefined state encoding goes to Arm.
- Latency: the byte completes on detection cycle D of the 8th rise_evt. RX_DATA and RX_VALID are visible in cycle D+1. Total latency from the external SCLK edge is about SYNC_STAGES+2 CLK.
- RX_VALID / RX_ACK rules:
  - RX_ACK while RX_VALID=1 clears RX_VALID on the next edge.
  - RX_ACK while RX_VALID=0 is ignored.
  - Completion while RX_VALID=1 and RX_ACK=0: RX_DATA is overwritten with the new byte, RX_VALID stays 1, RX_OVR pulses for 1 cycle.
  - Completion in the same cycle as RX_ACK: the new byte is loaded, RX_VALID stays 1, no RX_OVR.
- Simultaneous events:
  - synced CS rise and rise_evt in the same cycle: CS wins, the bit is ignored, FRAME_ERR follows the pre-existing bit_cnt.
  - rise_evt while in Arm or Idle: ignored.
- Reset mid-frame: all state is cleared and the block enters Arm. No FRAME_ERR is generated. RX_VALID=0 and the held byte is lost.
- Falling SCLK edges are not used.
- There is no transmit path; SDO is not driven by this block.

Test Plan:
- Single byte: CS low, send 0xA5 with 16-CLK half periods, CS high → exactly one RX_VALID rise, RX_DATA=0xA5, FRAME_ERR=0, RX_OVR=0, BUSY low after CS high.
- Burst with ack: one frame carrying 0x3C, 0xFF, 0x00, RX_ACK pulsed after each → three valid events in order with matching data, no RX_OVR, no FRAME_ERR.
- Overrun: send 0x12 then 0x34 without RX_ACK → RX_OVR pulses once at the second completion, RX_DATA=0x34, RX_VALID stays 1. Then RX_ACK → RX_VALID=0.
- Ack collision: assert RX_ACK on the exact cycle the second byte 0x56 completes → RX_VALID remains 1, RX_DATA=0x56, RX_OVR=0.
- Framing error: CS low, 5 bits of 0b10110, CS high → FRAME_ERR single pulse, RX_VALID unchanged. A following full frame with 0x81 is received correctly.
- Reset mid-frame: assert RST after 3 bits with CS still low, release, finish that frame, then send a new frame with 0xC3 → no output from the interrupted frame (state Arm until CS high), then RX_DATA=0xC3 with no FRAME_ERR.
